// File: rtl/riscv_mc_ctrl_if.sv
// Control bus between the multicycle RISC-V controller (master) and its datapath (slave).
// CNT_W must match the CNT_W of the riscv_mc_ctrl instance bound to this bus.
interface riscv_mc_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       op;
    logic             zero;
    logic             mem_ready;

    logic             mem_req;
    logic             mem_write;
    logic             adr_src;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       result_src;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic             illegal_instr;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        output alu_src_a, alu_src_b, alu_op, result_src,
        output state, instr_count, illegal_instr
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        input  alu_src_a, alu_src_b, alu_op, result_src,
        input  state, instr_count, illegal_instr
    );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RISC-V main controller: Moore FSM with registered control outputs.
// Optional CTRL_ILLEGAL_TRAP_EN: unknown opcodes halt the core and raise illegal_instr.
module riscv_mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    riscv_mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StHalt     = 4'd11
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic       pc_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_e IllegalNext = StHalt;
`else
    localparam state_e IllegalNext = StFetch;
`endif

    state_e           r_state;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_count;
    state_e           w_next;
    logic             w_retire;
    logic             w_fetch_done;

    // Moore decode of one state; FETCH's ir/pc strobes and BEQ's branch are added at the outputs.
    function automatic ctrl_t f_decode(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            StDecode: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            StMemAdr: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            StMemRead: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            StMemWb: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            StMemWrite: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            StExecR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            StAluWb: begin
                c.reg_write = 1'b1;
            end
            StExecI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            StJal: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_write  = 1'b1;
            end
            StBeq: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // r_ctrl.mem_req is low in the first cycle after reset release, so no access starts until
    // the first rising edge afterwards.
    assign w_fetch_done = (r_state == StFetch) && r_ctrl.mem_req && bus.mem_ready;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            StFetch: begin
                if (w_fetch_done) w_next = StDecode;
            end
            StDecode: begin
                case (bus.op)
                    OpLoad, OpStore: w_next = StMemAdr;
                    OpRType:         w_next = StExecR;
                    OpIType:         w_next = StExecI;
                    OpJal:           w_next = StJal;
                    OpBranch:        w_next = StBeq;
                    default:         w_next = IllegalNext;
                endcase
            end
            StMemAdr:  w_next = (bus.op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead: begin
                if (bus.mem_ready) w_next = StMemWb;
            end
            StMemWb: begin
                w_next   = StFetch;
                w_retire = 1'b1;
            end
            StMemWrite: begin
                if (bus.mem_ready) begin
                    w_next   = StFetch;
                    w_retire = 1'b1;
                end
            end
            StExecR, StExecI, StJal: w_next = StAluWb;
            StAluWb, StBeq: begin
                w_next   = StFetch;
                w_retire = 1'b1;
            end
            StHalt:  w_next = StHalt;
            default: w_next = StFetch;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= (w_next == StHalt);
        end
    end

    assign bus.illegal_instr = r_illegal;
`else
    assign bus.illegal_instr = 1'b0;
`endif

    // Asynchronous clear of r_ctrl is what drops mem_req the instant reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StFetch;
            r_ctrl  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_decode(w_next);
            if (w_retire) r_count <= r_count + CntOne;
        end
    end

    assign bus.mem_req     = r_ctrl.mem_req;
    assign bus.mem_write   = r_ctrl.mem_write;
    assign bus.adr_src     = r_ctrl.adr_src;
    assign bus.reg_write   = r_ctrl.reg_write;
    assign bus.alu_src_a   = r_ctrl.alu_src_a;
    assign bus.alu_src_b   = r_ctrl.alu_src_b;
    assign bus.alu_op      = r_ctrl.alu_op;
    assign bus.result_src  = r_ctrl.result_src;
    assign bus.ir_write    = w_fetch_done;
    assign bus.pc_write    = r_ctrl.pc_write | w_fetch_done | ((r_state == StBeq) & bus.zero);
    assign bus.state       = r_state;
    assign bus.instr_count = r_count;

    a_no_write_clash: assert property (@(posedge clk) disable iff (!reset)
        !(bus.mem_write && (bus.ir_write || bus.pc_write)));

`ifndef CTRL_ILLEGAL_TRAP_EN
    a_halt_unreachable: assert property (@(posedge clk) disable iff (!reset)
        r_state != StHalt);
`endif
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: instruction vector table, directed corner sequences
// and randomized stimulus against a cycle-level reference model.
module tb_riscv_mc_ctrl;
    localparam logic [6:0] OpLw  = 7'h03;
    localparam logic [6:0] OpSw  = 7'h23;
    localparam logic [6:0] OpR   = 7'h33;
    localparam logic [6:0] OpI   = 7'h13;
    localparam logic [6:0] OpJal = 7'h6F;
    localparam logic [6:0] OpBeq = 7'h63;
    localparam logic [6:0] OpBad = 7'h7F;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op_i;
    logic       zero_i;
    logic       rdy_i;

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_state;
    int unsigned m_count;
    bit          m_active;
    int unsigned exp_total;

    always #5 clk = ~clk;

    riscv_mc_ctrl_if #(.CNT_W(32)) bus  ();
    riscv_mc_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus.op         = op_i;
    assign bus.zero       = zero_i;
    assign bus.mem_ready  = rdy_i;
    assign bus4.op        = op_i;
    assign bus4.zero      = zero_i;
    assign bus4.mem_ready = rdy_i;

    riscv_mc_ctrl #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
    riscv_mc_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [1:0] res;
    } exp_t;

    typedef struct {
        logic [6:0]      op;
        bit              zero;
        int              len;
        logic [4:0][3:0] path;
        int              inc;
        int              pcw;
        int              regw;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output table from the state descriptions; everything is zero before the first fetch.
    function automatic exp_t expected(int s, bit act, bit z, bit rdy);
        exp_t e;
        e = '0;
        if (act) begin
            case (s)
                0: begin
                    e.mem_req = 1'b1; e.src_b = 2'b10; e.res = 2'b10;
                    e.ir_write = rdy; e.pc_write = rdy;
                end
                1: begin e.src_a = 2'b01; e.src_b = 2'b01; end
                2: begin e.src_a = 2'b10; e.src_b = 2'b01; end
                3: begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
                4: begin e.res = 2'b01; e.reg_write = 1'b1; end
                5: begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; end
                6: begin e.src_a = 2'b10; e.alu_op = 2'b10; end
                7: e.reg_write = 1'b1;
                8: begin e.src_a = 2'b10; e.src_b = 2'b01; e.alu_op = 2'b10; end
                9: begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1; end
                10: begin e.src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z; end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic model_reset();
        m_state   = 0;
        m_count   = 0;
        m_active  = 1'b0;
        exp_total = 0;
    endtask

    task automatic model_edge();
        int nx;
        bit ret;
        if (reset !== 1'b1) return;
        if (!m_active) begin
            m_active = 1'b1;
            return;
        end
        nx  = m_state;
        ret = 1'b0;
        case (m_state)
            0: if (rdy_i) nx = 1;
            1: begin
                if (op_i == OpLw || op_i == OpSw) nx = 2;
                else if (op_i == OpR)   nx = 6;
                else if (op_i == OpI)   nx = 8;
                else if (op_i == OpJal) nx = 9;
                else if (op_i == OpBeq) nx = 10;
                else                    nx = Trap ? 11 : 0;
            end
            2: nx = (op_i == OpLw) ? 3 : 5;
            3: if (rdy_i) nx = 4;
            5: if (rdy_i) begin nx = 0; ret = 1'b1; end
            6, 8, 9: nx = 7;
            4, 7, 10: begin nx = 0; ret = 1'b1; end
            default: nx = m_state;
        endcase
        m_state = nx;
        if (ret) m_count++;
    endtask

    // One clock: compare everything on the falling edge, advance the model on the rising edge.
    task automatic step();
        exp_t e;
        exp_t a;
        @(negedge clk);
        e = expected(m_state, m_active, zero_i, rdy_i);
        a = {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write,
             bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src};
        check("ctrl_outputs", a, e);
        check("state", bus.state, m_state);
        check("instr_count", bus.instr_count, m_count);
        check("instr_count_w4", bus4.instr_count, m_count % 16);
        check("illegal_instr", bus.illegal_instr, m_state == 11);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Called just after a rising edge: assert reset mid-cycle and check the immediate effect.
    task automatic async_reset(input int hold);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_state", bus.state, 0);
        check("rst_count", bus.instr_count, 0);
        check("rst_count_w4", bus4.instr_count, 0);
        for (int i = 0; i < hold; i++) step();
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int pcw;
        int regw;
        op_i   = v.op;
        zero_i = v.zero;
        rdy_i  = 1'b1;
        pcw    = 0;
        regw   = 0;
        #1;
        for (int k = 0; k < v.len; k++) begin
            check("path_state", bus.state, v.path[k]);
            pcw  += int'(bus.pc_write);
            regw += int'(bus.reg_write);
            step();
        end
        exp_total += v.inc;
        check("end_in_fetch", bus.state, 0);
        check("retired", bus.instr_count, exp_total);
        check("pc_write_cycles", pcw, v.pcw);
        check("reg_write_cycles", regw, v.regw);
    endtask

    function automatic logic [4:0][3:0] mk(int a, int b, int c, int d, int e);
        logic [4:0][3:0] p;
        p[0] = a[3:0]; p[1] = b[3:0]; p[2] = c[3:0]; p[3] = d[3:0]; p[4] = e[3:0];
        return p;
    endfunction

    vec_t vecs[8];

    initial begin
        vecs[0] = '{op: OpR,   zero: 0, len: 4, path: mk(0, 1, 6, 7, 0),  inc: 1, pcw: 1, regw: 1};
        vecs[1] = '{op: OpI,   zero: 0, len: 4, path: mk(0, 1, 8, 7, 0),  inc: 1, pcw: 1, regw: 1};
        vecs[2] = '{op: OpJal, zero: 0, len: 4, path: mk(0, 1, 9, 7, 0),  inc: 1, pcw: 2, regw: 1};
        vecs[3] = '{op: OpLw,  zero: 0, len: 5, path: mk(0, 1, 2, 3, 4),  inc: 1, pcw: 1, regw: 1};
        vecs[4] = '{op: OpSw,  zero: 1, len: 4, path: mk(0, 1, 2, 5, 0),  inc: 1, pcw: 1, regw: 0};
        vecs[5] = '{op: OpBeq, zero: 1, len: 3, path: mk(0, 1, 10, 0, 0), inc: 1, pcw: 2, regw: 0};
        vecs[6] = '{op: OpBeq, zero: 0, len: 3, path: mk(0, 1, 10, 0, 0), inc: 1, pcw: 1, regw: 0};
        vecs[7] = '{op: OpBad, zero: 0, len: 2, path: mk(0, 1, 0, 0, 0),  inc: 0, pcw: 1, regw: 0};

        reset  = 1'b0;
        op_i   = '0;
        zero_i = 1'b0;
        rdy_i  = 1'b1;
        model_reset();
        step();
        step();
        reset = 1'b1;
        step();

        // R, I, jal back to back, then the remaining table rows.
        for (int i = 0; i < 3; i++) run_vec(vecs[i]);
        check("count_after_r_i_jal", bus.instr_count, 3);
        for (int i = 3; i < 7; i++) run_vec(vecs[i]);

`ifdef CTRL_ILLEGAL_TRAP_EN
        op_i = OpBad;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            check("halt_state", bus.state, 11);
            check("halt_illegal", bus.illegal_instr, 1'b1);
            check("halt_mem_req", bus.mem_req, 1'b0);
            step();
        end
        check("halt_count", bus.instr_count, exp_total);
        async_reset(1);
        step();
`else
        run_vec(vecs[7]);
        check("illegal_tied_low", bus.illegal_instr, 1'b0);
`endif

        // Store with a slow memory: the write strobe must hold until mem_ready.
        op_i  = OpSw;
        rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                rdy_i = 1'b1;
                #1;
            end
            check("sw_hold_state", bus.state, 5);
            check("sw_hold_mem_write", bus.mem_write, 1'b1);
            check("sw_hold_adr_src", bus.adr_src, 1'b1);
            check("sw_hold_no_reg_write", bus.reg_write, 1'b0);
            step();
        end
        exp_total++;
        check("sw_back_in_fetch", bus.state, 0);
        check("sw_retired", bus.instr_count, exp_total);

        // Reset lands in the middle of a load's memory access.
        op_i  = OpLw;
        rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rdy_i = 1'b0;
        step();
        check("memread_pending", bus.state, 3);
        check("memread_mem_req", bus.mem_req, 1'b1);
        async_reset(2);
        step();

        // Sixteen retirements wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) run_vec(vecs[0]);
        check("wrap_count_w4", bus4.instr_count, 0);
        check("wrap_count_w32", bus.instr_count, 16);

        for (int c = 0; c < 4000; c++) begin
            case ($urandom_range(0, 7))
                0: op_i = OpLw;
                1: op_i = OpSw;
                2: op_i = OpR;
                3: op_i = OpI;
                4: op_i = OpJal;
                5: op_i = OpBeq;
                default: op_i = 7'($urandom_range(0, 127));
            endcase
            zero_i = 1'($urandom_range(0, 1));
            rdy_i  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) async_reset(1 + int'($urandom_range(0, 2)));
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
